wheel_speed_ramp: RTL and testbench

Upstream command stage for the wheel motor controller. Accepts target speed commands over a valid/ready handshake and drives a 3-bit bin_speed output that steps toward the target one level at a time, at a programmable rate. This limits acceleration and deceleration of the stepper-driven wheel. Includes an emergency-stop path that forces speed 0 immediately.

---
 rtl/wheel_speed_ramp_if.sv | 9 +
 rtl/wheel_speed_ramp.sv | 108 ++++++++++
 tb/tb_wheel_speed_ramp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wheel_speed_ramp_if.sv
// Target-speed command handshake between the motion planner and the wheel speed ramp.
interface wheel_speed_ramp_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_speed;

  modport master (output cmd_valid, output cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/wheel_speed_ramp.sv
// Rate-limited speed ramp: walks bin_speed one level per RAMP_DIV cycles toward the
// latched target, with an emergency stop that forces speed 0 on the next edge.
module wheel_speed_ramp #(
  parameter int unsigned RAMP_DIV  = 1000,
  parameter int unsigned MAX_SPEED = 7
) (
  input  logic                clk,
  input  logic                rst,
  wheel_speed_ramp_if.slave   cmd,
  input  logic                estop,
  output logic [2:0]          bin_speed,
  output logic                at_target,
  output logic                done,
  output logic                busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SPD_W = 3;
  localparam logic [CNT_W-1:0] STEP_AT = CNT_W'(RAMP_DIV - 1);
  localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(MAX_SPEED);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    ESTOP = 2'd2
  } state_t;

  state_t             state;
  logic [SPD_W-1:0]   target;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic [SPD_W-1:0]   cmd_clamped;
  logic [SPD_W-1:0]   eff_target;
  logic [SPD_W-1:0]   stepped_speed;
  logic               step_now;

  assign cmd.cmd_ready = (state != ESTOP) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_clamped   = (cmd.cmd_speed > SPD_MAX) ? SPD_MAX : cmd.cmd_speed;

  // A command landing on a step edge steers that very step.
  assign eff_target    = accept ? cmd_clamped : target;
  assign step_now      = (count == STEP_AT);
  assign stepped_speed = (eff_target > bin_speed) ? bin_speed + SPD_W'(1)
                                                  : bin_speed - SPD_W'(1);

  assign busy      = (state == RAMP);
  assign at_target = (state == IDLE);

  // Sequencer: reset, then estop, then command accept, then prescaled stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      bin_speed <= '0;
      count     <= '0;
      done      <= 1'b0;
    end else if (estop) begin
      state     <= ESTOP;
      target    <= '0;
      bin_speed <= '0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        target <= cmd_clamped;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_clamped == bin_speed) begin
              done <= 1'b1;
            end else begin
              count <= '0;
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (accept && (cmd_clamped == bin_speed)) begin
            // Retargeted onto the current level: finish without another step.
            state <= IDLE;
            count <= '0;
            done  <= 1'b1;
          end else if (step_now) begin
            count     <= '0;
            bin_speed <= stepped_speed;
            if (stepped_speed == eff_target) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ESTOP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_speed_ramp.sv
// Scoreboard bench for wheel_speed_ramp: an event-time reference model predicts each
// cycle's outputs, a separate monitor pops and compares after every rising edge.
module tb_wheel_speed_ramp;

  localparam int unsigned DIV  = 4;
  localparam int unsigned MAXS = 5;

  logic       clk;
  logic       rst;
  logic       estop;
  logic [2:0] bin_speed;
  logic       at_target;
  logic       done;
  logic       busy;

  wheel_speed_ramp_if cmd_if ();

  wheel_speed_ramp #(.RAMP_DIV(DIV), .MAX_SPEED(MAXS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .estop     (estop),
    .bin_speed (bin_speed),
    .at_target (at_target),
    .done      (done),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned edge_idx;
    int          speed;
    bit          done;
    bit          busy;
    bit          at_target;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks;
  int unsigned n_fail;
  bit          armed;
  int unsigned pe;

  // Reference model: speed level, target, and the absolute edge of the next step.
  int          m_speed;
  int          m_target;
  bit          m_ramp;
  bit          m_stop;
  int unsigned m_next;

  function automatic void check(string name, int act, int exp, int unsigned at);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, at, act, exp);
    end
  endfunction

  // One clock of stimulus; the model predicts the outcome of the coming rising edge.
  task automatic drive(input bit r, input bit e, input bit v, input logic [2:0] s);
    exp_t        x;
    bit          dn;
    bit          exp_ready;
    int unsigned eidx;
    @(negedge clk);
    rst              = r;
    estop            = e;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_speed = s;
    eidx      = pe + 1;
    exp_ready = !e && !m_stop;
    dn        = 1'b0;
    if (r) begin
      m_speed = 0; m_target = 0; m_ramp = 0; m_stop = 0;
    end else if (e) begin
      m_speed = 0; m_target = 0; m_ramp = 0; m_stop = 1;
    end else if (m_stop) begin
      m_stop = 0;
    end else begin
      if (v) m_target = (int'(s) > int'(MAXS)) ? int'(MAXS) : int'(s);
      if (!m_ramp) begin
        if (v) begin
          if (m_target == m_speed) dn = 1'b1;
          else begin
            m_ramp = 1;
            m_next = eidx + DIV;
          end
        end
      end else if (v && (m_target == m_speed)) begin
        m_ramp = 0;
        dn     = 1'b1;
      end else if (eidx == m_next) begin
        m_speed += (m_target > m_speed) ? 1 : -1;
        m_next  += DIV;
        if (m_speed == m_target) begin
          m_ramp = 0;
          dn     = 1'b1;
        end
      end
    end
    x.edge_idx  = eidx;
    x.speed     = m_speed;
    x.done      = dn;
    x.busy      = m_ramp;
    x.at_target = !m_ramp && !m_stop;
    sb.push_back(x);
    armed = 1'b1;
    #1;
    check("cmd_ready", int'(cmd_if.cmd_ready), int'(exp_ready), eidx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'($urandom_range(7)));
  endtask

  task automatic send(input logic [2:0] s);
    drive(1'b0, 1'b0, 1'b1, s);
  endtask

  // Monitor: compares every presented output cycle against the oldest prediction.
  initial begin
    exp_t x;
    pe = 0;
    forever begin
      @(posedge clk);
      pe++;
      #1;
      if (armed) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow edge %0d: got empty queue expected an entry", pe);
        end else begin
          x = sb.pop_front();
          check("bin_speed", int'(bin_speed), x.speed, x.edge_idx);
          check("done", int'(done), int'(x.done), x.edge_idx);
          check("busy", int'(busy), int'(x.busy), x.edge_idx);
          check("at_target", int'(at_target), int'(x.at_target), x.edge_idx);
          check("speed_limit", int'(bin_speed <= 3'(MAXS)), 1, x.edge_idx);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    m_speed  = 0; m_target = 0; m_ramp = 0; m_stop = 0; m_next = 0;
    rst              = 1'b1;
    estop            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_speed = 3'd0;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 3'd0);
    send(3'd3); idle(16);
    send(3'd5); idle(24); send(3'd2); idle(16);
    send(3'd0); idle(12);
    send(3'd6); idle(9); send(3'd1); idle(12);
    send(3'd7); idle(24);
    send(3'd0); idle(24);
    send(3'd5); idle(15);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 3'd3);
    drive(1'b0, 1'b0, 1'b1, 3'd3);
    idle(4);
    send(3'd4); idle(6);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    idle(2); send(3'd0); idle(3);

    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(39) == 0),
            ($urandom_range(5) == 0), 3'($urandom_range(7)));
    end
    idle(40);

    @(posedge clk);
    #2;
    armed = 1'b0;
    check("scoreboard_drain", sb.size(), 0, pe);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
